// File: rtl/tilt_lane_controller.sv
// Tilt-to-lane controller: debounces signed X-tilt samples into
// single left/right lane moves, with release hysteresis and edge bumps.
module tilt_lane_controller #(
    parameter int TILT_THRESH = 6,
    parameter int HYST        = 2,
    parameter int DEBOUNCE    = 4,
    parameter int NUM_LANES   = 3,
    parameter int START_LANE  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] acl_data,
    input  logic       acl_valid,
    output logic [1:0] lane,
    output logic       move_left,
    output logic       move_right,
    output logic       bump,
    output logic [2:0] tilt_state
);

    typedef enum logic [2:0] {
        CENTER = 3'd0,
        PEND_L = 3'd1,
        PEND_R = 3'd2,
        HELD_L = 3'd3,
        HELD_R = 3'd4
    } state_t;

    localparam logic signed [5:0] TH  = 6'(TILT_THRESH);
    localparam logic signed [5:0] REL = 6'(TILT_THRESH - HYST);
    localparam logic [1:0] LANE_MAX   = 2'(NUM_LANES - 1);
    localparam logic [1:0] LANE_START = 2'(START_LANE);
    localparam logic [4:0] DEB        = 5'(DEBOUNCE);
    localparam bit         DEB1       = (DEBOUNCE == 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic        ml_q, ml_d;
    logic        mr_q, mr_d;
    logic        bump_q, bump_d;

    logic signed [5:0] xs;
    logic        is_l, is_r, rel_l, rel_r;
    logic        deb_hit;
    logic [3:0]  cnt_inc;
    logic        fire_l, fire_r;

    assign xs      = {acl_data[4], acl_data};
    assign is_l    = (xs <= -TH);
    assign is_r    = (xs >= TH);
    assign rel_l   = (xs > -REL);
    assign rel_r   = (xs < REL);
    assign deb_hit = (({1'b0, cnt_q} + 5'd1) >= DEB);
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    // State, debounce count, lane and registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CENTER;
            cnt_q   <= 4'd0;
            lane_q  <= LANE_START;
            ml_q    <= 1'b0;
            mr_q    <= 1'b0;
            bump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            ml_q    <= ml_d;
            mr_q    <= mr_d;
            bump_q  <= bump_d;
        end
    end

    // Next-state: classify valid samples, debounce, then fire moves
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        ml_d    = 1'b0;
        mr_d    = 1'b0;
        bump_d  = 1'b0;
        fire_l  = 1'b0;
        fire_r  = 1'b0;
        if (acl_valid) begin
            unique case (state_q)
                CENTER, HELD_L, HELD_R: begin
                    if (is_l && state_q != HELD_L) begin
                        if (DEB1) begin
                            fire_l = 1'b1;
                        end else begin
                            state_d = PEND_L;
                            cnt_d   = 4'd1;
                        end
                    end else if (is_r && state_q != HELD_R) begin
                        if (DEB1) begin
                            fire_r = 1'b1;
                        end else begin
                            state_d = PEND_R;
                            cnt_d   = 4'd1;
                        end
                    end else if (state_q == HELD_L && rel_l) begin
                        state_d = CENTER;
                        cnt_d   = 4'd0;
                    end else if (state_q == HELD_R && rel_r) begin
                        state_d = CENTER;
                        cnt_d   = 4'd0;
                    end
                end
                PEND_L: begin
                    if (is_l) begin
                        if (deb_hit) fire_l = 1'b1;
                        else         cnt_d  = cnt_inc;
                    end else if (is_r) begin
                        state_d = PEND_R;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = CENTER;
                        cnt_d   = 4'd0;
                    end
                end
                PEND_R: begin
                    if (is_r) begin
                        if (deb_hit) fire_r = 1'b1;
                        else         cnt_d  = cnt_inc;
                    end else if (is_l) begin
                        state_d = PEND_L;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = CENTER;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = CENTER;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        if (fire_l) begin
            state_d = HELD_L;
            cnt_d   = 4'd0;
            if (lane_q != 2'd0) begin
                lane_d = lane_q - 2'd1;
                ml_d   = 1'b1;
            end else begin
                bump_d = 1'b1;
            end
        end
        if (fire_r) begin
            state_d = HELD_R;
            cnt_d   = 4'd0;
            if (lane_q < LANE_MAX) begin
                lane_d = lane_q + 2'd1;
                mr_d   = 1'b1;
            end else begin
                bump_d = 1'b1;
            end
        end
    end

    assign lane       = lane_q;
    assign move_left  = ml_q;
    assign move_right = mr_q;
    assign bump       = bump_q;
    assign tilt_state = state_q;

endmodule

// File: tb/tb_tilt_lane_controller.sv
// Directed bench for tilt_lane_controller: debounce, hysteresis,
// edge bump, valid gating and mid-sequence reset.
module tb_tilt_lane_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] acl_data;
    logic       acl_valid;
    logic [1:0] lane;
    logic       move_left;
    logic       move_right;
    logic       bump;
    logic [2:0] tilt_state;

    int n_chk  = 0;
    int n_fail = 0;
    int mr_cnt;
    int any_pulse;

    tilt_lane_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acl_data   (acl_data),
        .acl_valid  (acl_valid),
        .lane       (lane),
        .move_left  (move_left),
        .move_right (move_right),
        .bump       (bump),
        .tilt_state (tilt_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int ln, input int ml,
                        input int mr, input int bp, input int st);
        chk({tag, ".lane"}, 32'(lane), 32'(ln));
        chk({tag, ".ml"}, 32'(move_left), 32'(ml));
        chk({tag, ".mr"}, 32'(move_right), 32'(mr));
        chk({tag, ".bump"}, 32'(bump), 32'(bp));
        chk({tag, ".state"}, 32'(tilt_state), 32'(st));
    endtask

    // One valid strobe; returns at the following negedge with results visible
    task automatic send(input int x);
        @(negedge clk);
        acl_data  = 5'(x);
        acl_valid = 1'b1;
        @(negedge clk);
        acl_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        acl_data  = 5'd0;
        acl_valid = 1'b0;
        repeat (2) @(negedge clk);
        // 1: reset state
        outs("t1_reset", 1, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle();

        // 2: four -8 with idle cycles -> one move_left
        send(-8); idle();
        send(-8); idle();
        send(-8);
        outs("t2_pend", 1, 0, 0, 0, 1);
        idle();
        send(-8);
        outs("t2_fire", 0, 1, 0, 0, 3);
        idle();
        chk("t2_pulse_width", 32'(move_left), 32'd0);

        // 3: three -8 then 0 -> no move, back to CENTER
        do_reset();
        send(-8); send(-8); send(-8);
        send(0);
        outs("t3_abort", 1, 0, 0, 0, 0);

        // threshold boundaries and direction switch
        send(5);
        chk("thr_p5", 32'(tilt_state), 32'd0);
        send(-5);
        chk("thr_m5", 32'(tilt_state), 32'd0);
        send(-6);
        chk("thr_m6", 32'(tilt_state), 32'd1);
        send(6);
        chk("thr_switch", 32'(tilt_state), 32'd2);
        send(5);
        chk("thr_drop", 32'(tilt_state), 32'd0);

        // 4: twenty +9 -> exactly one move_right
        mr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            send(9);
            if (move_right) mr_cnt++;
        end
        chk("t4_mr_count", 32'(mr_cnt), 32'd1);
        outs("t4_end", 2, 0, 0, 0, 4);

        // 5: release, four +9 at right edge -> bump
        send(0);
        chk("t5_release", 32'(tilt_state), 32'd0);
        send(9); send(9); send(9); send(9);
        outs("t5_bump", 2, 0, 0, 1, 4);

        // 6: hysteresis in HELD_L
        send(0);
        send(-8); send(-8); send(-8); send(-8);
        outs("t6_fire", 1, 1, 0, 0, 3);
        send(-5);
        outs("t6_hold", 1, 0, 0, 0, 3);
        send(-3);
        outs("t6_rel", 1, 0, 0, 0, 0);

        // 7: second move_left
        send(-8); send(-8); send(-8); send(-8);
        outs("t7_fire", 0, 1, 0, 0, 3);
        send(0);

        // 8: invalid samples are ignored
        any_pulse = 0;
        acl_data  = 5'(-16);
        acl_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (move_left || move_right || bump || tilt_state != 3'd0)
                any_pulse++;
        end
        chk("t8_no_change", 32'(any_pulse), 32'd0);
        outs("t8_end", 0, 0, 0, 0, 0);

        // 9: reset during PEND_R with cnt=3
        send(9); send(9); send(9);
        chk("t9_pend", 32'(tilt_state), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        outs("t9_async", 1, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        outs("t9_after", 1, 0, 0, 0, 0);
        send(9); send(9); send(9);
        outs("t9_cnt_cleared", 1, 0, 0, 0, 2);
        send(9);
        outs("t9_refire", 2, 0, 1, 0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
